// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the single-bus RISC CPU control path:
//   - ALU operation type and the 5-bit opcode encodings (shared with the ALU)
//   - sequencer state enum
//   - instruction class enum and opcode-to-class helper
//   - packed strobe vector produced by the control decoder
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_OPC_W = 5;
    localparam int CPU_ST_W  = 5;

    typedef logic [CPU_OPC_W-1:0] alu_op_t;

    localparam alu_op_t OP_LD   = 5'd0;
    localparam alu_op_t OP_LDI  = 5'd1;
    localparam alu_op_t OP_ST   = 5'd2;
    localparam alu_op_t OP_ADD  = 5'd3;
    localparam alu_op_t OP_SUB  = 5'd4;
    localparam alu_op_t OP_AND  = 5'd5;
    localparam alu_op_t OP_OR   = 5'd6;
    localparam alu_op_t OP_SHR  = 5'd7;
    localparam alu_op_t OP_SHL  = 5'd8;
    localparam alu_op_t OP_ROR  = 5'd9;
    localparam alu_op_t OP_ROL  = 5'd10;
    localparam alu_op_t OP_ADDI = 5'd11;
    localparam alu_op_t OP_ANDI = 5'd12;
    localparam alu_op_t OP_ORI  = 5'd13;
    localparam alu_op_t OP_MUL  = 5'd14;
    localparam alu_op_t OP_DIV  = 5'd15;
    localparam alu_op_t OP_NEG  = 5'd16;
    localparam alu_op_t OP_NOT  = 5'd17;
    localparam alu_op_t OP_BR   = 5'd18;
    localparam alu_op_t OP_JR   = 5'd19;
    localparam alu_op_t OP_MFHI = 5'd23;
    localparam alu_op_t OP_MFLO = 5'd24;
    localparam alu_op_t OP_NOP  = 5'd25;
    localparam alu_op_t OP_HALT = 5'd26;

    // S_T0..S_T2 are the common fetch; S_T3 is the decode cycle and also the
    // first execute step of every class; S_T4..S_T7 are later execute steps.
    typedef enum logic [CPU_ST_W-1:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_UN,
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_MD,
        CLS_BR,
        CLS_JR,
        CLS_MFHI,
        CLS_MFLO,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } op_class_t;

    typedef struct packed {
        logic    g_ra;
        logic    g_rb;
        logic    g_rc;
        logic    r_in;
        logic    r_out;
        logic    ba_out;
        logic    c_out;
        logic    pc_out;
        logic    pc_in;
        logic    inc_pc;
        logic    ir_in;
        logic    mar_in;
        logic    mdr_in;
        logic    mdr_out;
        logic    read;
        logic    write;
        logic    y_in;
        logic    z_in;
        logic    zlow_out;
        logic    zhigh_out;
        logic    hi_in;
        logic    lo_in;
        logic    hi_out;
        logic    lo_out;
        logic    con_in;
        alu_op_t alu_op;
    } ctrl_t;

    function automatic op_class_t op_class(input alu_op_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       return CLS_IMM;
            OP_NEG, OP_NOT:                 return CLS_UN;
            OP_LDI:                         return CLS_LDI;
            OP_LD:                          return CLS_LD;
            OP_ST:                          return CLS_ST;
            OP_MUL, OP_DIV:                 return CLS_MD;
            OP_BR:                          return CLS_BR;
            OP_JR:                          return CLS_JR;
            OP_MFHI:                        return CLS_MFHI;
            OP_MFLO:                        return CLS_MFLO;
            OP_NOP:                         return CLS_NOP;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// -----------------------------------------------------------------------------
// ctrl_decode
// Pure combinational map from (sequencer state, opcode, branch flag) to the
// full datapath/memory strobe vector. Any strobe not set for a state is 0.
// Ports:
//   state_i  : current sequencer state
//   opc_i    : opcode field ir[31:27]
//   con_ff_i : branch condition flag (gates PC_In on the last br step)
//   ctrl_o   : strobe vector including alu_op
// -----------------------------------------------------------------------------
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t  state_i,
    input  alu_op_t opc_i,
    input  logic    con_ff_i,
    output ctrl_t   ctrl_o
);

    op_class_t cls;

    always_comb begin
        cls    = op_class(opc_i);
        ctrl_o = '0;
        case (state_i)
            S_T0: begin
                ctrl_o.pc_out = 1'b1;
                ctrl_o.mar_in = 1'b1;
                ctrl_o.inc_pc = 1'b1;
            end
            S_T1: begin
                ctrl_o.read   = 1'b1;
                ctrl_o.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_o.mdr_out = 1'b1;
                ctrl_o.ir_in   = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_ALU, CLS_IMM: begin
                        ctrl_o.g_rb  = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.y_in  = 1'b1;
                    end
                    CLS_UN: begin
                        ctrl_o.g_rb   = 1'b1;
                        ctrl_o.r_out  = 1'b1;
                        ctrl_o.z_in   = 1'b1;
                        ctrl_o.alu_op = opc_i;
                    end
                    // Base-or-zero register feeds Y for address formation.
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl_o.g_rb   = 1'b1;
                        ctrl_o.ba_out = 1'b1;
                        ctrl_o.y_in   = 1'b1;
                    end
                    CLS_MD: begin
                        ctrl_o.g_ra  = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.y_in  = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_o.g_rb   = 1'b1;
                        ctrl_o.r_out  = 1'b1;
                        ctrl_o.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        ctrl_o.g_ra  = 1'b1;
                        ctrl_o.r_out = 1'b1;
                        ctrl_o.pc_in = 1'b1;
                    end
                    CLS_MFHI: begin
                        ctrl_o.hi_out = 1'b1;
                        ctrl_o.g_ra   = 1'b1;
                        ctrl_o.r_in   = 1'b1;
                    end
                    CLS_MFLO: begin
                        ctrl_o.lo_out = 1'b1;
                        ctrl_o.g_ra   = 1'b1;
                        ctrl_o.r_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_ALU: begin
                        ctrl_o.g_rc   = 1'b1;
                        ctrl_o.r_out  = 1'b1;
                        ctrl_o.z_in   = 1'b1;
                        ctrl_o.alu_op = opc_i;
                    end
                    CLS_IMM: begin
                        ctrl_o.c_out  = 1'b1;
                        ctrl_o.z_in   = 1'b1;
                        ctrl_o.alu_op = opc_i;
                    end
                    CLS_UN: begin
                        ctrl_o.zlow_out = 1'b1;
                        ctrl_o.g_ra     = 1'b1;
                        ctrl_o.r_in     = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl_o.c_out  = 1'b1;
                        ctrl_o.z_in   = 1'b1;
                        ctrl_o.alu_op = OP_ADD;
                    end
                    CLS_MD: begin
                        ctrl_o.g_rb   = 1'b1;
                        ctrl_o.r_out  = 1'b1;
                        ctrl_o.z_in   = 1'b1;
                        ctrl_o.alu_op = opc_i;
                    end
                    CLS_BR: begin
                        ctrl_o.pc_out = 1'b1;
                        ctrl_o.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CLS_ALU, CLS_IMM, CLS_LDI: begin
                        ctrl_o.zlow_out = 1'b1;
                        ctrl_o.g_ra     = 1'b1;
                        ctrl_o.r_in     = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        ctrl_o.zlow_out = 1'b1;
                        ctrl_o.mar_in   = 1'b1;
                    end
                    CLS_MD: begin
                        ctrl_o.zlow_out = 1'b1;
                        ctrl_o.lo_in    = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_o.c_out  = 1'b1;
                        ctrl_o.z_in   = 1'b1;
                        ctrl_o.alu_op = OP_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CLS_LD: begin
                        ctrl_o.read   = 1'b1;
                        ctrl_o.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        ctrl_o.g_ra   = 1'b1;
                        ctrl_o.r_out  = 1'b1;
                        ctrl_o.mdr_in = 1'b1;
                    end
                    CLS_MD: begin
                        ctrl_o.zhigh_out = 1'b1;
                        ctrl_o.hi_in     = 1'b1;
                    end
                    // Target address is always driven; only the load is conditional.
                    CLS_BR: begin
                        ctrl_o.zlow_out = 1'b1;
                        ctrl_o.pc_in    = con_ff_i;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CLS_LD: begin
                        ctrl_o.mdr_out = 1'b1;
                        ctrl_o.g_ra    = 1'b1;
                        ctrl_o.r_in    = 1'b1;
                    end
                    CLS_ST: begin
                        ctrl_o.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// ctrl_sequencer
// Hardwired control unit: steps each instruction through a common fetch
// (T0..T2), decodes the opcode in T3 and walks the per-class execute steps,
// returning to T0 (or halting when stop is requested at the boundary).
// Optional macro CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the sequencer
// and set a sticky illegal_op output; without it they execute as nop.
// Ports:
//   clock, reset_n          : rising-edge clock, synchronous active-low reset
//   ir, con_ff              : instruction register, branch condition flag
//   mem_ready               : memory transfer completes this cycle
//   stop                    : halt at next instruction boundary
//   G_RA..CON_In, alu_op    : register-select, datapath and memory strobes
//   run                     : high while executing (not in reset or halt)
//   illegal_op (macro only) : sticky undefined-opcode flag
// -----------------------------------------------------------------------------
module ctrl_sequencer
    import cpu_pkg::*;
#(
    parameter int OPC_W = 5,
    parameter int ST_W  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      ir,
    input  logic             con_ff,
    input  logic             mem_ready,
    input  logic             stop,
    output logic             G_RA,
    output logic             G_RB,
    output logic             G_RC,
    output logic             R_In,
    output logic             R_Out,
    output logic             BA_Out,
    output logic             C_Out,
    output logic             PC_Out,
    output logic             PC_In,
    output logic             IncPC,
    output logic             IR_In,
    output logic             MAR_In,
    output logic             MDR_In,
    output logic             MDR_Out,
    output logic             Read,
    output logic             Write,
    output logic             Y_In,
    output logic             Z_In,
    output logic             Zlow_Out,
    output logic             Zhigh_Out,
    output logic             HI_In,
    output logic             LO_In,
    output logic             HI_Out,
    output logic             LO_Out,
    output logic             CON_In,
    output logic [OPC_W-1:0] alu_op,
    output logic             run
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             illegal_op
`endif
);

    logic [ST_W-1:0] state_q, state_d;
    logic [ST_W-1:0] to_t0;
    state_t          st;
    alu_op_t         opc;
    op_class_t       cls;
    ctrl_t           ctrl;
    logic            unused_ir;

    assign st        = state_t'(state_q);
    assign opc       = ir[31 -: OPC_W];
    assign unused_ir = ^ir[31-OPC_W:0];

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign illegal_op = illegal_q;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        cls     = op_class(opc);
        // Every return to the instruction boundary honours a pending stop.
        to_t0   = stop ? S_HALT : S_T0;
        state_d = state_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (st)
            S_RESET: state_d = to_t0;
            S_T0:    state_d = S_T1;
            S_T1:    if (mem_ready) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (cls)
                    CLS_JR, CLS_MFHI, CLS_MFLO, CLS_NOP: state_d = to_t0;
                    CLS_HALT: state_d = S_HALT;
                    CLS_ILL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
`else
                        state_d   = to_t0;
`endif
                    end
                    default: state_d = S_T4;
                endcase
            end
            S_T4: state_d = (cls == CLS_UN) ? to_t0 : S_T5;
            S_T5: begin
                if (cls == CLS_ALU || cls == CLS_IMM || cls == CLS_LDI) begin
                    state_d = to_t0;
                end else begin
                    state_d = S_T6;
                end
            end
            S_T6: begin
                case (cls)
                    CLS_LD:  if (mem_ready) state_d = S_T7;
                    CLS_ST:  state_d = S_T7;
                    default: state_d = to_t0;
                endcase
            end
            // Store holds Write here until memory acknowledges.
            S_T7: if (cls != CLS_ST || mem_ready) state_d = to_t0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    ctrl_decode u_decode (
        .state_i  (st),
        .opc_i    (opc),
        .con_ff_i (con_ff),
        .ctrl_o   (ctrl)
    );

    // Output logic
    always_comb begin
        G_RA      = ctrl.g_ra;
        G_RB      = ctrl.g_rb;
        G_RC      = ctrl.g_rc;
        R_In      = ctrl.r_in;
        R_Out     = ctrl.r_out;
        BA_Out    = ctrl.ba_out;
        C_Out     = ctrl.c_out;
        PC_Out    = ctrl.pc_out;
        PC_In     = ctrl.pc_in;
        IncPC     = ctrl.inc_pc;
        IR_In     = ctrl.ir_in;
        MAR_In    = ctrl.mar_in;
        MDR_In    = ctrl.mdr_in;
        MDR_Out   = ctrl.mdr_out;
        Read      = ctrl.read;
        Write     = ctrl.write;
        Y_In      = ctrl.y_in;
        Z_In      = ctrl.z_in;
        Zlow_Out  = ctrl.zlow_out;
        Zhigh_Out = ctrl.zhigh_out;
        HI_In     = ctrl.hi_in;
        LO_In     = ctrl.lo_in;
        HI_Out    = ctrl.hi_out;
        LO_Out    = ctrl.lo_out;
        CON_In    = ctrl.con_in;
        alu_op    = ctrl.alu_op;
        run       = (st != S_RESET) && (st != S_HALT);
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    logic        clock = 1'b0;
    logic        reset_n, con_ff, mem_ready, stop;
    logic [31:0] ir;
    logic G_RA, G_RB, G_RC, R_In, R_Out, BA_Out, C_Out, PC_Out, PC_In, IncPC;
    logic IR_In, MAR_In, MDR_In, MDR_Out, Read, Write, Y_In, Z_In, Zlow_Out;
    logic Zhigh_Out, HI_In, LO_In, HI_Out, LO_Out, CON_In, run;
    logic [4:0] alu_op;
    logic       ill_w;

    always #5 clock = ~clock;

    ctrl_sequencer dut (
        .clock(clock), .reset_n(reset_n), .ir(ir), .con_ff(con_ff),
        .mem_ready(mem_ready), .stop(stop),
        .G_RA(G_RA), .G_RB(G_RB), .G_RC(G_RC), .R_In(R_In), .R_Out(R_Out),
        .BA_Out(BA_Out), .C_Out(C_Out), .PC_Out(PC_Out), .PC_In(PC_In),
        .IncPC(IncPC), .IR_In(IR_In), .MAR_In(MAR_In), .MDR_In(MDR_In),
        .MDR_Out(MDR_Out), .Read(Read), .Write(Write), .Y_In(Y_In), .Z_In(Z_In),
        .Zlow_Out(Zlow_Out), .Zhigh_Out(Zhigh_Out), .HI_In(HI_In), .LO_In(LO_In),
        .HI_Out(HI_Out), .LO_Out(LO_Out), .CON_In(CON_In), .alu_op(alu_op),
        .run(run)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .illegal_op(ill_w)
`endif
    );

`ifndef CTRL_ILLEGAL_TRAP_EN
    assign ill_w = 1'b0;
`endif

    localparam logic [24:0] M_GRA   = 25'd1 << 0;
    localparam logic [24:0] M_GRB   = 25'd1 << 1;
    localparam logic [24:0] M_GRC   = 25'd1 << 2;
    localparam logic [24:0] M_RIN   = 25'd1 << 3;
    localparam logic [24:0] M_ROUT  = 25'd1 << 4;
    localparam logic [24:0] M_BAOUT = 25'd1 << 5;
    localparam logic [24:0] M_COUT  = 25'd1 << 6;
    localparam logic [24:0] M_PCOUT = 25'd1 << 7;
    localparam logic [24:0] M_PCIN  = 25'd1 << 8;
    localparam logic [24:0] M_INCPC = 25'd1 << 9;
    localparam logic [24:0] M_IRIN  = 25'd1 << 10;
    localparam logic [24:0] M_MARIN = 25'd1 << 11;
    localparam logic [24:0] M_MDRIN = 25'd1 << 12;
    localparam logic [24:0] M_MDROUT= 25'd1 << 13;
    localparam logic [24:0] M_READ  = 25'd1 << 14;
    localparam logic [24:0] M_WRITE = 25'd1 << 15;
    localparam logic [24:0] M_YIN   = 25'd1 << 16;
    localparam logic [24:0] M_ZIN   = 25'd1 << 17;
    localparam logic [24:0] M_ZLOW  = 25'd1 << 18;
    localparam logic [24:0] M_ZHIGH = 25'd1 << 19;
    localparam logic [24:0] M_HIIN  = 25'd1 << 20;
    localparam logic [24:0] M_LOIN  = 25'd1 << 21;
    localparam logic [24:0] M_HIOUT = 25'd1 << 22;
    localparam logic [24:0] M_LOOUT = 25'd1 << 23;
    localparam logic [24:0] M_CONIN = 25'd1 << 24;
    localparam logic [24:0] M_NONE  = 25'd0;

    logic [31:0] act_v;
    assign act_v = {ill_w, run, alu_op, CON_In, LO_Out, HI_Out, LO_In, HI_In,
                    Zhigh_Out, Zlow_Out, Z_In, Y_In, Write, Read, MDR_Out, MDR_In,
                    MAR_In, IR_In, IncPC, PC_In, PC_Out, C_Out, BA_Out, R_Out,
                    R_In, G_RC, G_RB, G_RA};

    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] ev(input logic [24:0] m, input logic [4:0] op,
                                       input logic r, input logic il);
        return {il, r, op, m};
    endfunction

    // Monitor: compares one expected cycle per falling edge
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (act_v !== mon_e.v) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", mon_e.name, act_v, mon_e.v);
            end
            total++;
            if ((int'(G_RA) + int'(G_RB) + int'(G_RC)) > 1 || (R_In && R_Out)) begin
                bad++;
                $display("FAIL %s_excl: got ga/gb/gc=%b%b%b rin/rout=%b%b want <=1 select and not both",
                         mon_e.name, G_RA, G_RB, G_RC, R_In, R_Out);
            end
        end
    end

    task automatic step(input string nm, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.v    = v;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string nm, input logic [31:0] iv, input int dly);
        ir        = iv;
        mem_ready = 1'b0;
        step({nm, ":T0"}, ev(M_PCOUT | M_MARIN | M_INCPC, 5'd0, 1'b1, 1'b0));
        for (int i = 0; i <= dly; i++) begin
            mem_ready = (i == dly);
            step({nm, ":T1"}, ev(M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0));
        end
        mem_ready = 1'b0;
        step({nm, ":T2"}, ev(M_MDROUT | M_IRIN, 5'd0, 1'b1, 1'b0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ir = 32'h0; con_ff = 1'b0; mem_ready = 1'b0; stop = 1'b0;
        @(posedge clock);
        #1;
        step("rst_a", ev(M_NONE, 5'd0, 1'b0, 1'b0));
        reset_n = 1'b1;
        step("rst_b", ev(M_NONE, 5'd0, 1'b0, 1'b0));

        // add R1,R2,R3
        fetch("add", 32'h18918000, 0);
        step("add:T3", ev(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0));
        step("add:T4", ev(M_GRC | M_ROUT | M_ZIN, 5'd3, 1'b1, 1'b0));
        step("add:T5", ev(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0));

        // addi R4,R5,7
        fetch("addi", {5'd11, 4'd4, 4'd5, 19'd7}, 1);
        step("addi:T3", ev(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0));
        step("addi:T4", ev(M_COUT | M_ZIN, 5'd11, 1'b1, 1'b0));
        step("addi:T5", ev(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0));

        // neg R6,R7
        fetch("neg", {5'd16, 4'd6, 4'd7, 19'd0}, 0);
        step("neg:T3", ev(M_GRB | M_ROUT | M_ZIN, 5'd16, 1'b1, 1'b0));
        step("neg:T4", ev(M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0));

        // ld R1,0x45(R2) with memory answering on the 4th read cycle
        fetch("ld", 32'h00900045, 0);
        step("ld:T3", ev(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1, 1'b0));
        step("ld:T4", ev(M_COUT | M_ZIN, 5'd3, 1'b1, 1'b0));
        step("ld:T5", ev(M_ZLOW | M_MARIN, 5'd0, 1'b1, 1'b0));
        for (int i = 0; i <= 3; i++) begin
            mem_ready = (i == 3);
            step("ld:T6", ev(M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0));
        end
        mem_ready = 1'b0;
        step("ld:T7", ev(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0));

        // br not taken, then taken
        con_ff = 1'b0;
        fetch("br0", {5'd18, 4'd2, 4'd0, 19'h10}, 0);
        step("br0:T3", ev(M_GRB | M_ROUT | M_CONIN, 5'd0, 1'b1, 1'b0));
        step("br0:T4", ev(M_PCOUT | M_YIN, 5'd0, 1'b1, 1'b0));
        step("br0:T5", ev(M_COUT | M_ZIN, 5'd3, 1'b1, 1'b0));
        step("br0:T6", ev(M_ZLOW, 5'd0, 1'b1, 1'b0));
        con_ff = 1'b1;
        fetch("br1", {5'd18, 4'd2, 4'd0, 19'h10}, 0);
        step("br1:T3", ev(M_GRB | M_ROUT | M_CONIN, 5'd0, 1'b1, 1'b0));
        step("br1:T4", ev(M_PCOUT | M_YIN, 5'd0, 1'b1, 1'b0));
        step("br1:T5", ev(M_COUT | M_ZIN, 5'd3, 1'b1, 1'b0));
        step("br1:T6", ev(M_ZLOW | M_PCIN, 5'd0, 1'b1, 1'b0));
        con_ff = 1'b0;

        // single-step classes
        fetch("jr", {5'd19, 4'd5, 23'd0}, 0);
        step("jr:T3", ev(M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b1, 1'b0));
        fetch("mflo", {5'd24, 4'd7, 23'd0}, 0);
        step("mflo:T3", ev(M_LOOUT | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0));
        fetch("nop", {5'd25, 27'd0}, 0);
        step("nop:T3", ev(M_NONE, 5'd0, 1'b1, 1'b0));

        // st, reset while Write waits on memory
        fetch("st", {5'd2, 4'd1, 4'd2, 19'h20}, 0);
        step("st:T3", ev(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b1, 1'b0));
        step("st:T4", ev(M_COUT | M_ZIN, 5'd3, 1'b1, 1'b0));
        step("st:T5", ev(M_ZLOW | M_MARIN, 5'd0, 1'b1, 1'b0));
        step("st:T6", ev(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1, 1'b0));
        step("st:T7a", ev(M_WRITE, 5'd0, 1'b1, 1'b0));
        reset_n = 1'b0;
        step("st:T7b", ev(M_WRITE, 5'd0, 1'b1, 1'b0));
        reset_n = 1'b1;
        step("st:rst", ev(M_NONE, 5'd0, 1'b0, 1'b0));

        // undefined opcode
        fetch("ill", {5'd31, 27'd0}, 0);
        step("ill:T3", ev(M_NONE, 5'd0, 1'b1, 1'b0));
`ifdef CTRL_ILLEGAL_TRAP_EN
        step("ill:halt_a", ev(M_NONE, 5'd0, 1'b0, 1'b1));
        reset_n = 1'b0;
        step("ill:halt_b", ev(M_NONE, 5'd0, 1'b0, 1'b1));
        reset_n = 1'b1;
        step("ill:rst", ev(M_NONE, 5'd0, 1'b0, 1'b0));
`endif

        // halt instruction, recovered by reset
        fetch("halt", {5'd26, 27'd0}, 0);
        step("halt:T3", ev(M_NONE, 5'd0, 1'b1, 1'b0));
        step("halt:S_a", ev(M_NONE, 5'd0, 1'b0, 1'b0));
        reset_n = 1'b0;
        step("halt:S_b", ev(M_NONE, 5'd0, 1'b0, 1'b0));
        reset_n = 1'b1;
        step("halt:rst", ev(M_NONE, 5'd0, 1'b0, 1'b0));

        // mul with stop raised mid-instruction
        fetch("mul", {5'd14, 4'd3, 4'd4, 19'd0}, 0);
        step("mul:T3", ev(M_GRA | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0));
        step("mul:T4", ev(M_GRB | M_ROUT | M_ZIN, 5'd14, 1'b1, 1'b0));
        stop = 1'b1;
        step("mul:T5", ev(M_ZLOW | M_LOIN, 5'd0, 1'b1, 1'b0));
        step("mul:T6", ev(M_ZHIGH | M_HIIN, 5'd0, 1'b1, 1'b0));
        step("mul:halt_a", ev(M_NONE, 5'd0, 1'b0, 1'b0));
        stop = 1'b0;
        step("mul:halt_b", ev(M_NONE, 5'd0, 1'b0, 1'b0));

        @(negedge clock);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
